// File: rtl/alu_seq_unit_pkg.sv
// Shared definitions for the sequential ALU.
//   - Opcode encodings (4-bit op field)
//   - Controller state encoding (IDLE / BUSY / HOLD)
//   - Registered flag bundle type
package alu_seq_pkg;

   localparam logic [3:0] OP_XOR   = 4'b0000;
   localparam logic [3:0] OP_AND   = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_COMP  = 4'b0011;
   localparam logic [3:0] OP_SHIFT = 4'b0100;
   localparam logic [3:0] OP_PASS  = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_MUL   = 4'b0111;
   localparam logic [3:0] OP_OR    = 4'b1000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   typedef struct packed {
      logic zero;
      logic sign;
      logic carry;
      logic overflow;
   } alu_flags_t;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Operation / result bus of the sequential ALU.
//   in_valid/in_ready   : operation handshake (a, b, op, shift_dir, shift_arith)
//   out_valid/out_ready : result handshake (result + four flags)
// master = producer of operations / consumer of results, slave = the ALU.
interface alu_seq_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic             shift_dir;
   logic             shift_arith;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero_flag;
   logic             sign_flag;
   logic             carry_flag;
   logic             overflow_flag;

   modport master (
      output in_valid, a, b, op, shift_dir, shift_arith, out_ready,
      input  in_ready, out_valid, result, zero_flag, sign_flag, carry_flag, overflow_flag
   );

   modport slave (
      input  in_valid, a, b, op, shift_dir, shift_arith, out_ready,
      output in_ready, out_valid, result, zero_flag, sign_flag, carry_flag, overflow_flag
   );
endinterface

// File: rtl/alu_seq_unit_seq_multiplier.sv
// Iterative unsigned shift-add multiplier, one bit of b per cycle, LSB first.
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : latch a_i/b_i and begin (ignored while busy)
//   a_i, b_i   : WIDTH-bit operands
//   done_o     : high during the last iteration cycle
//   product_o  : full 2*WIDTH product, valid while done_o is high
// Iterations run in the WIDTH cycles after start; the final partial sum is
// exposed combinationally so the caller can capture it on the last edge.
module seq_multiplier #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);
   localparam int unsigned CntW = $clog2(WIDTH);

   logic               busy_q, busy_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_step;
   logic               last;

   assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last      = busy_q && (cnt_q == CntW'(WIDTH - 1));
   assign done_o    = last;
   assign product_o = acc_step;

   always_comb begin
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (busy_q) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CntW'(1);
         if (last) begin
            busy_d = 1'b0;
         end
      end else if (start_i) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered ALU with valid/ready handshakes and an iterative multiplier.
//   clk, rst : clock, synchronous active-high reset
//   bus_io   : slave side of alu_seq_unit_if (operation in, result + flags out)
// Single-cycle ops land in HOLD one cycle after acceptance; MUL spends WIDTH
// cycles in BUSY first. In HOLD, a drain and a new accept on the same edge
// overwrite result/flags with the new op.
module alu_seq_unit
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter bit          MUL_EN = 1'b1
) (
   input logic           clk,
   input logic           rst,
   alu_seq_unit_if.slave bus_io
);
   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   alu_flags_t         flags_q, flags_d;

   logic               in_ready;
   logic               accept;
   logic               is_mul;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   logic [SHAMT_W-1:0] shamt;
   logic               sub_sel;
   logic [WIDTH-1:0]   add_b;
   logic [WIDTH:0]     add_sum;
   logic               add_ovf;
   logic [WIDTH-1:0]   alu_res;
   alu_flags_t         alu_flg;
   logic               zs_en;
   logic               alu_carry;
   logic               alu_ovf;

   // ---------------- handshake ----------------
   always_comb begin
      unique case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_HOLD: in_ready = bus_io.out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept = bus_io.in_valid && in_ready;
   assign is_mul = MUL_EN && (bus_io.op == OP_MUL);

   // ---------------- combinational datapath ----------------
   assign shamt   = bus_io.b[SHAMT_W-1:0];
   assign sub_sel = (bus_io.op == OP_SUB);
   // SUB reuses the adder as a + ~b + 1, so carry-out means "no borrow".
   assign add_b   = sub_sel ? ~bus_io.b : bus_io.b;
   assign add_sum = {1'b0, bus_io.a} + {1'b0, add_b} + {{WIDTH{1'b0}}, sub_sel};
   assign add_ovf = (bus_io.a[WIDTH-1] == add_b[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != bus_io.a[WIDTH-1]);

   always_comb begin
      alu_res   = bus_io.a;
      zs_en     = 1'b0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (bus_io.op)
         OP_XOR: begin
            alu_res = bus_io.a ^ bus_io.b;
            zs_en   = 1'b1;
         end
         OP_AND: begin
            alu_res = bus_io.a & bus_io.b;
            zs_en   = 1'b1;
         end
         OP_OR: begin
            alu_res = bus_io.a | bus_io.b;
            zs_en   = 1'b1;
         end
         OP_ADD, OP_SUB: begin
            alu_res   = add_sum[WIDTH-1:0];
            zs_en     = 1'b1;
            alu_carry = add_sum[WIDTH];
            alu_ovf   = add_ovf;
         end
         OP_COMP: begin
            alu_res = ~bus_io.b + WIDTH'(1);
            zs_en   = 1'b1;
         end
         OP_SHIFT: begin
            // Arithmetic mode always shifts right regardless of shift_dir.
            if (bus_io.shift_arith) begin
               alu_res = $signed(bus_io.a) >>> shamt;
            end else if (bus_io.shift_dir) begin
               alu_res = bus_io.a >> shamt;
            end else begin
               alu_res = bus_io.a << shamt;
            end
         end
         OP_PASS: begin
            zs_en = 1'b1;
         end
         default: begin
            // Undefined codes (and MUL when MUL_EN=0): pass A, flags clear.
         end
      endcase
      alu_flg.zero     = zs_en && (alu_res == '0);
      alu_flg.sign     = zs_en && alu_res[WIDTH-1];
      alu_flg.carry    = alu_carry;
      alu_flg.overflow = alu_ovf;
   end

   // ---------------- multiplier ----------------
   seq_multiplier #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start_i   (accept && is_mul),
      .a_i       (bus_io.a),
      .b_i       (bus_io.b),
      .done_o    (mul_done),
      .product_o (mul_prod)
   );

   // ---------------- control ----------------
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         ST_IDLE, ST_HOLD: begin
            if (accept) begin
               if (is_mul) begin
                  state_d = ST_BUSY;
               end else begin
                  state_d  = ST_HOLD;
                  result_d = alu_res;
                  flags_d  = alu_flg;
               end
            end else if ((state_q == ST_HOLD) && bus_io.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mul_done) begin
               state_d          = ST_HOLD;
               result_d         = mul_prod[WIDTH-1:0];
               flags_d.zero     = (mul_prod[WIDTH-1:0] == '0);
               flags_d.sign     = mul_prod[WIDTH-1];
               flags_d.carry    = 1'b0;
               flags_d.overflow = |mul_prod[2*WIDTH-1:WIDTH];
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   // ---------------- outputs ----------------
   assign bus_io.in_ready      = in_ready;
   assign bus_io.out_valid     = (state_q == ST_HOLD);
   assign bus_io.result        = result_q;
   assign bus_io.zero_flag     = flags_q.zero;
   assign bus_io.sign_flag     = flags_q.sign;
   assign bus_io.carry_flag    = flags_q.carry;
   assign bus_io.overflow_flag = flags_q.overflow;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (WIDTH=32, MUL_EN=1).
module tb_alu_seq_unit;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   alu_seq_unit_if #(.WIDTH(W)) bus ();

   alu_seq_unit #(
      .WIDTH  (W),
      .MUL_EN (1'b1)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // Reference: {result, zero, sign, carry, overflow} from plain arithmetic.
   function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic dir,
                                         input logic arith);
      logic [31:0] r;
      logic        zs, c, v;
      logic [63:0] p;
      longint      sa, sb, sr, rs;
      int          sh;
      r  = a;
      zs = 1'b0;
      c  = 1'b0;
      v  = 1'b0;
      sa = $signed(a);
      sb = $signed(b);
      sh = int'(b % 32);
      case (op)
         4'd0: begin r = a ^ b; zs = 1'b1; end
         4'd1: begin r = a & b; zs = 1'b1; end
         4'd8: begin r = a | b; zs = 1'b1; end
         4'd2: begin
            p  = 64'(a) + 64'(b);
            r  = p[31:0];
            c  = p[32];
            sr = sa + sb;
            rs = $signed(r);
            v  = (sr != rs);
            zs = 1'b1;
         end
         4'd6: begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
            rs = $signed(r);
            v  = (sr != rs);
            zs = 1'b1;
         end
         4'd3: begin r = 32'd0 - b; zs = 1'b1; end
         4'd4: begin
            if (arith) r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            else if (dir) r = a >> sh;
            else r = a << sh;
         end
         4'd5: zs = 1'b1;
         4'd7: begin
            p  = 64'(a) * 64'(b);
            r  = p[31:0];
            v  = (p[63:32] != 32'h0);
            zs = 1'b1;
         end
         default: ;
      endcase
      return {r, zs && (r == 32'h0), zs && r[31], c, v};
   endfunction

   function automatic logic [35:0] observed();
      return {bus.result, bus.zero_flag, bus.sign_flag, bus.carry_flag, bus.overflow_flag};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic dir, input logic arith);
      bus.op          = op;
      bus.a           = a;
      bus.b           = b;
      bus.shift_dir   = dir;
      bus.shift_arith = arith;
      bus.in_valid    = 1'b1;
   endtask

   task automatic flush();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst             = 1'b1;
      bus.in_valid    = 1'b0;
      bus.out_ready   = 1'b0;
      bus.a           = '0;
      bus.b           = '0;
      bus.op          = '0;
      bus.shift_dir   = 1'b0;
      bus.shift_arith = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01)
         $display("FAIL reset_hs: got %b required 01", {bus.out_valid, bus.in_ready});
      else passed++;
      checks++;
      if (observed() !== 36'h0)
         $display("FAIL reset_data: got %h required 0", observed());
      else passed++;
   endtask

   task automatic test_add_sub();
      logic [35:0] exp[3];
      logic [31:0] av[3];
      logic [31:0] bv[3];
      logic [3:0]  ov[3];
      exp[0] = {32'h8000_0000, 4'b0101}; av[0] = 32'h7FFF_FFFF; bv[0] = 32'h1; ov[0] = 4'd2;
      exp[1] = {32'h0000_0000, 4'b1010}; av[1] = 32'h5;         bv[1] = 32'h5; ov[1] = 4'd6;
      exp[2] = {32'hFFFF_FFFE, 4'b0100}; av[2] = 32'h3;         bv[2] = 32'h5; ov[2] = 4'd6;
      flush();
      for (int i = 0; i < 3; i++) begin
         set_op(ov[i], av[i], bv[i], 1'b0, 1'b0);
         tick();
         bus.in_valid = 1'b0;
         checks++;
         if ({bus.out_valid, observed()} !== {1'b1, exp[i]})
            $display("FAIL addsub_%0d: got v=%b %h required v=1 %h",
                     i, bus.out_valid, observed(), exp[i]);
         else passed++;
      end
   endtask

   task automatic test_shift();
      logic [35:0] exp;
      logic [31:0] ra, rb;
      logic        rd, rr;
      logic [35:0] dexp[3];
      logic        ddir[3];
      logic        dar[3];
      dexp[0] = {32'hF800_0000, 4'b0}; ddir[0] = 1'b0; dar[0] = 1'b1;
      dexp[1] = {32'h0800_0000, 4'b0}; ddir[1] = 1'b1; dar[1] = 1'b0;
      dexp[2] = {32'h0000_0000, 4'b0}; ddir[2] = 1'b0; dar[2] = 1'b0;
      flush();
      for (int i = 0; i < 3; i++) begin
         set_op(4'd4, 32'h8000_0000, 32'd4, ddir[i], dar[i]);
         tick();
         checks++;
         if (observed() !== dexp[i])
            $display("FAIL shift_dir_%0d: got %h required %h", i, observed(), dexp[i]);
         else passed++;
      end
      // Upper bits of b must not affect the amount; amount 0 returns a.
      set_op(4'd4, 32'h1234_5678, 32'hFFFF_FFE0, 1'b0, 1'b0);
      tick();
      checks++;
      if (observed() !== {32'h1234_5678, 4'b0})
         $display("FAIL shift_zero: got %h required %h", observed(), {32'h1234_5678, 4'b0});
      else passed++;
      for (int i = 0; i < 10; i++) begin
         ra = $urandom;
         rb = $urandom;
         rd = 1'($urandom_range(0, 1));
         rr = 1'($urandom_range(0, 1));
         exp = model(4'd4, ra, rb, rd, rr);
         set_op(4'd4, ra, rb, rd, rr);
         tick();
         checks++;
         if (observed() !== exp)
            $display("FAIL shift_rand: a=%h b=%h d=%b ar=%b got %h required %h",
                     ra, rb, rd, rr, observed(), exp);
         else passed++;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_mul();
      logic [35:0] exp[2];
      logic [31:0] av[2];
      logic [31:0] bv[2];
      int          n;
      logic        rdy_seen;
      exp[0] = {32'h0, 4'b1001}; av[0] = 32'h0001_0000; bv[0] = 32'h0001_0000;
      exp[1] = {32'd42, 4'b0000}; av[1] = 32'd7;        bv[1] = 32'd6;
      flush();
      for (int i = 0; i < 2; i++) begin
         set_op(4'd7, av[i], bv[i], 1'b0, 1'b0);
         tick();
         bus.in_valid = 1'b0;
         n = 0;
         rdy_seen = 1'b0;
         while (!bus.out_valid && n < 40) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            n++;
            tick();
         end
         checks++;
         if (n !== 32) $display("FAIL mul_latency_%0d: got %0d busy cycles required 32", i, n);
         else passed++;
         checks++;
         if (rdy_seen !== 1'b0) $display("FAIL mul_in_ready_%0d: got 1 while busy required 0", i);
         else passed++;
         checks++;
         if (observed() !== exp[i])
            $display("FAIL mul_result_%0d: got %h required %h", i, observed(), exp[i]);
         else passed++;
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [37:0] hold_exp;
      hold_exp = {1'b1, 1'b0, 32'h0F0F_0F0F, 4'b0000};
      flush();
      bus.out_ready = 1'b0;
      set_op(4'd0, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      tick();
      set_op(4'd1, 32'h1234_5678, 32'h0FF0_0FF0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bus.out_valid, bus.in_ready, observed()} !== hold_exp)
            $display("FAIL bp_hold_%0d: got %h required %h",
                     i, {bus.out_valid, bus.in_ready, observed()}, hold_exp);
         else passed++;
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL bp_ready: got %b required 1", bus.in_ready);
      else passed++;
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if ({bus.out_valid, observed()} !== {1'b1, 32'h0230_0670, 4'b0000})
         $display("FAIL bp_and: got v=%b %h required v=1 %h",
                  bus.out_valid, observed(), {32'h0230_0670, 4'b0000});
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [35:0] exp;
      logic [31:0] ra, rb;
      logic [3:0]  rop;
      logic        rd, rr;
      flush();
      for (int i = 0; i < 24; i++) begin
         rop = 4'($urandom_range(0, 15));
         if (rop == 4'd7) rop = 4'd2;
         ra = (i % 6 == 0) ? rb : $urandom;
         rb = $urandom;
         rd = 1'($urandom_range(0, 1));
         rr = 1'($urandom_range(0, 1));
         exp = model(rop, ra, rb, rd, rr);
         set_op(rop, ra, rb, rd, rr);
         checks++;
         if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got 0 required 1", i);
         else passed++;
         tick();
         checks++;
         if ({bus.out_valid, observed()} !== {1'b1, exp})
            $display("FAIL b2b_%0d: op=%h a=%h b=%h got v=%b %h required v=1 %h",
                     i, rop, ra, rb, bus.out_valid, observed(), exp);
         else passed++;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic test_random_stall();
      logic [35:0] q[$];
      logic [35:0] front;
      logic        acc, drn;
      int          guard;
      flush();
      tick();
      for (int i = 0; i < 400; i++) begin
         set_op(4'($urandom_range(0, 15)), $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         acc = bus.in_valid && bus.in_ready;
         drn = bus.out_valid && bus.out_ready;
         if (drn) begin
            front = (q.size() > 0) ? q.pop_front() : 36'hX;
            checks++;
            if (observed() !== front)
               $display("FAIL stall_out_%0d: got %h required %h", i, observed(), front);
            else passed++;
         end
         if (acc) q.push_back(model(bus.op, bus.a, bus.b, bus.shift_dir, bus.shift_arith));
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      guard = 0;
      while (q.size() > 0 && guard < 80) begin
         #1;
         if (bus.out_valid) begin
            front = q.pop_front();
            checks++;
            if (observed() !== front)
               $display("FAIL stall_drain: got %h required %h", observed(), front);
            else passed++;
         end
         guard++;
         tick();
      end
      checks++;
      if (q.size() != 0) $display("FAIL stall_pending: got %0d results left required 0", q.size());
      else passed++;
   endtask

   task automatic test_reset_mid_mul();
      logic stale;
      flush();
      set_op(4'd7, $urandom | 32'h1, $urandom | 32'h1, 1'b0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({bus.out_valid, bus.in_ready, observed()} !== {1'b0, 1'b1, 36'h0})
         $display("FAIL rst_mul: got %h required %h",
                  {bus.out_valid, bus.in_ready, observed()}, {1'b0, 1'b1, 36'h0});
      else passed++;
      stale = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid) stale = 1'b1;
         tick();
      end
      checks++;
      if (stale !== 1'b0) $display("FAIL rst_stale: got out_valid=1 required 0");
      else passed++;
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_shift();
      test_mul();
      test_backpressure();
      test_back_to_back();
      test_random_stall();
      test_reset_mid_mul();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
